// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, parity codes and data-width limits.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   localparam int unsigned DATA_W_MAX = 9;
   localparam int unsigned BIT_W      = $clog2(DATA_W_MAX);

   // Reserved code 2'b11 behaves as no parity.
   function automatic logic par_enabled(input logic [1:0] mode);
      return (mode != PAR_NONE) && (mode != 2'b11);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable divisor counter: bit_tick on the last cycle of a bit period,
// pre_tick one cycle earlier (divisor is never below 2).
module uart_baud_tick #(
   parameter int unsigned DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             bit_tick,
   output logic             pre_tick
);

   logic [DIV_W-1:0] cnt;

   assign bit_tick = en && (cnt == div - DIV_W'(1));
   assign pre_tick = en && (cnt == div - DIV_W'(2));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= bit_tick ? '0 : cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with valid/ready intake; divisor, parity and
// stop-bit count are captured per frame at the accept edge.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 40_000_000,
   parameter int unsigned UART_BPS = 128000,
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DIV_W    = 16
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [DATA_W-1:0] tx_data,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic [1:0]        cfg_parity,
   input  logic              cfg_stop2,
   output logic              uart_tx_busy,
   output logic              tx_done,
   output logic              uart_txd
);

   localparam logic [DIV_W-1:0] RST_DIV = DIV_W'(CLK_FREQ / UART_BPS);

   state_t             state;
   logic [DATA_W-1:0]  sh_q;
   logic [BIT_W-1:0]   bit_cnt;
   logic [DIV_W-1:0]   div_q;
   logic               par_en_q;
   logic               par_bit_q;
   logic               stop2_q;
   logic               stop_second;
   logic               accept;
   logic               bit_tick;
   logic               pre_tick;

   assign tx_ready = (state == IDLE);
   assign accept   = tx_valid && tx_ready;

   uart_baud_tick #(.DIV_W(DIV_W)) u_baud (
      .clk      (sys_clk),
      .rst      (sys_rst),
      .clear    (accept),
      .en       (uart_tx_busy),
      .div      (div_q),
      .bit_tick (bit_tick),
      .pre_tick (pre_tick)
   );

   // The final stop period ends one cycle early in state terms so that IDLE
   // (and tx_ready) coincides with the last stop cycle, allowing zero-gap frames.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state        <= IDLE;
         uart_txd     <= 1'b1;
         tx_done      <= 1'b0;
         uart_tx_busy <= 1'b0;
         sh_q         <= '0;
         bit_cnt      <= '0;
         div_q        <= RST_DIV;
         par_en_q     <= 1'b0;
         par_bit_q    <= 1'b0;
         stop2_q      <= 1'b0;
         stop_second  <= 1'b0;
      end else begin
         tx_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state        <= START;
                  uart_txd     <= 1'b0;
                  uart_tx_busy <= 1'b1;
                  sh_q         <= tx_data;
                  div_q        <= (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
                  par_en_q     <= par_enabled(cfg_parity);
                  par_bit_q    <= (cfg_parity == PAR_ODD) ? ~^tx_data : ^tx_data;
                  stop2_q      <= cfg_stop2;
                  stop_second  <= 1'b0;
               end
            end
            START: begin
               if (bit_tick) begin
                  state    <= DATA;
                  uart_txd <= sh_q[0];
                  sh_q     <= sh_q >> 1;
                  bit_cnt  <= '0;
               end
            end
            DATA: begin
               if (bit_tick) begin
                  if (bit_cnt == BIT_W'(DATA_W - 1)) begin
                     if (par_en_q) begin
                        state    <= PARITY;
                        uart_txd <= par_bit_q;
                     end else begin
                        state    <= STOP;
                        uart_txd <= 1'b1;
                     end
                  end else begin
                     uart_txd <= sh_q[0];
                     sh_q     <= sh_q >> 1;
                     bit_cnt  <= bit_cnt + BIT_W'(1);
                  end
               end
            end
            PARITY: begin
               if (bit_tick) begin
                  state    <= STOP;
                  uart_txd <= 1'b1;
               end
            end
            STOP: begin
               if ((!stop2_q || stop_second) && pre_tick) begin
                  state        <= IDLE;
                  uart_tx_busy <= 1'b0;
                  tx_done      <= 1'b1;
               end else if (bit_tick) begin
                  stop_second <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed cases plus random frames
// compared cycle by cycle against an expected line waveform built from the frame format.
module tb_uart_tx_cfg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DIV_W  = 16;

   logic              sys_clk = 1'b0;
   logic              sys_rst;
   logic              tx_valid;
   logic              tx_ready;
   logic [DATA_W-1:0] tx_data;
   logic [DIV_W-1:0]  cfg_div;
   logic [1:0]        cfg_parity;
   logic              cfg_stop2;
   logic              uart_tx_busy;
   logic              tx_done;
   logic              uart_txd;

   int n_assert = 0;
   int n_fail   = 0;

   uart_tx_cfg #(
      .CLK_FREQ (40_000_000),
      .UART_BPS (128000),
      .DATA_W   (DATA_W),
      .DIV_W    (DIV_W)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .tx_data      (tx_data),
      .cfg_div      (cfg_div),
      .cfg_parity   (cfg_parity),
      .cfg_stop2    (cfg_stop2),
      .uart_tx_busy (uart_tx_busy),
      .tx_done      (tx_done),
      .uart_txd     (uart_txd)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [DATA_W-1:0] d, input int div, input logic [1:0] par,
                        input logic s2);
      tx_data    = d;
      cfg_div    = DIV_W'(div);
      cfg_parity = par;
      cfg_stop2  = s2;
      tx_valid   = 1'b1;
   endtask

   // Called at a negedge with a request presented; returns at the negedge of the
   // frame's last cycle so a held request can be re-driven for a zero-gap follow-up.
   task automatic expect_frame(input logic [DATA_W-1:0] d, input int div, input logic [1:0] par,
                               input logic s2, input bit hold, input bit scramble,
                               input string name);
      int   de;
      int   ones;
      int   len;
      logic bits[$];
      de   = (div < 2) ? 2 : div;
      ones = 0;
      bits.push_back(1'b0);
      for (int i = 0; i < int'(DATA_W); i++) begin
         bits.push_back(d[i]);
         ones += int'(d[i]);
      end
      if (par == 2'b01) bits.push_back(1'((ones % 2)));
      else if (par == 2'b10) bits.push_back(1'(1 - (ones % 2)));
      bits.push_back(1'b1);
      if (s2) bits.push_back(1'b1);
      len = bits.size() * de;

      check({name, " ready"}, 32'(tx_ready), 32'd1);
      @(posedge sys_clk);
      for (int i = 1; i <= len; i++) begin
         @(negedge sys_clk);
         check($sformatf("%s txd c%0d", name, i), 32'(uart_txd), 32'(bits[(i - 1) / de]));
         check($sformatf("%s done c%0d", name, i), 32'(tx_done), 32'(i == len));
         check($sformatf("%s busy c%0d", name, i), 32'(uart_tx_busy), 32'(i != len));
         check($sformatf("%s rdy c%0d", name, i), 32'(tx_ready), 32'(i == len));
         if (i == 1 && !hold) tx_valid = 1'b0;
         if (scramble && i == 3) begin
            tx_data    = DATA_W'($urandom);
            cfg_div    = DIV_W'(10);
            cfg_parity = 2'($urandom);
            cfg_stop2  = 1'($urandom);
         end
      end
   endtask

   task automatic idle_check(input string name);
      @(negedge sys_clk);
      check({name, " idle txd"}, 32'(uart_txd), 32'd1);
      check({name, " idle busy"}, 32'(uart_tx_busy), 32'd0);
      check({name, " idle done"}, 32'(tx_done), 32'd0);
      check({name, " idle rdy"}, 32'(tx_ready), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      logic [DATA_W-1:0] d;
      int                div;
      logic [1:0]        par;
      logic              s2;
      bit                hold;
      bit                scr;

      sys_rst    = 1'b1;
      tx_valid   = 1'b0;
      tx_data    = '0;
      cfg_div    = '0;
      cfg_parity = 2'b00;
      cfg_stop2  = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("rst txd", 32'(uart_txd), 32'd1);
      check("rst busy", 32'(uart_tx_busy), 32'd0);
      check("rst done", 32'(tx_done), 32'd0);
      sys_rst = 1'b0;
      idle_check("post-rst");

      drive(8'h55, 4, 2'b00, 1'b0);
      expect_frame(8'h55, 4, 2'b00, 1'b0, 1'b0, 1'b0, "t1");
      idle_check("t1");

      drive(8'h07, 4, 2'b01, 1'b0);
      expect_frame(8'h07, 4, 2'b01, 1'b0, 1'b0, 1'b0, "t2e");
      drive(8'h07, 4, 2'b10, 1'b0);
      expect_frame(8'h07, 4, 2'b10, 1'b0, 1'b0, 1'b0, "t2o");
      drive(8'h3C, 3, 2'b11, 1'b0);
      expect_frame(8'h3C, 3, 2'b11, 1'b0, 1'b0, 1'b0, "t2r");

      drive(8'hA0, 3, 2'b00, 1'b1);
      expect_frame(8'hA0, 3, 2'b00, 1'b1, 1'b0, 1'b1, "t3");
      idle_check("t3");

      drive(8'h01, 4, 2'b00, 1'b0);
      expect_frame(8'h01, 4, 2'b00, 1'b0, 1'b1, 1'b0, "t4a");
      drive(8'h02, 4, 2'b00, 1'b0);
      expect_frame(8'h02, 4, 2'b00, 1'b0, 1'b0, 1'b0, "t4b");
      idle_check("t4 gap1");
      idle_check("t4 gap2");

      drive(8'hC3, 4, 2'b00, 1'b0);
      @(posedge sys_clk);
      repeat (13) @(negedge sys_clk);
      tx_valid = 1'b0;
      sys_rst  = 1'b1;
      @(negedge sys_clk);
      check("t5 rst txd", 32'(uart_txd), 32'd1);
      check("t5 rst busy", 32'(uart_tx_busy), 32'd0);
      check("t5 rst rdy", 32'(tx_ready), 32'd1);
      check("t5 rst done", 32'(tx_done), 32'd0);
      sys_rst = 1'b0;
      repeat (4) idle_check("t5");
      drive(8'h96, 5, 2'b01, 1'b1);
      expect_frame(8'h96, 5, 2'b01, 1'b1, 1'b0, 1'b0, "t5 new");

      drive(8'hFF, 0, 2'b00, 1'b0);
      expect_frame(8'hFF, 0, 2'b00, 1'b0, 1'b0, 1'b0, "t6 div0");
      drive(8'h81, 1, 2'b10, 1'b1);
      expect_frame(8'h81, 1, 2'b10, 1'b1, 1'b0, 1'b0, "t6 div1");
      idle_check("t6");

      for (int k = 0; k < 24; k++) begin
         d    = DATA_W'($urandom);
         div  = int'($urandom_range(0, 6));
         par  = 2'($urandom_range(0, 3));
         s2   = 1'($urandom_range(0, 1));
         hold = bit'($urandom_range(0, 1));
         scr  = bit'($urandom_range(0, 1));
         drive(d, div, par, s2);
         expect_frame(d, div, par, s2, hold, scr, $sformatf("rnd%0d", k));
         if (!hold) idle_check($sformatf("rnd%0d", k));
      end
      tx_valid = 1'b0;
      @(negedge sys_clk);
      idle_check("end");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
